// File: rtl/layer8_argmax_pkg.sv
// Shared constants and state encoding for the layer-8 argmax classifier.
package layer8_argmax_pkg;

   // Class count follows the layer-7 fully-connected output width.
   localparam int LAYER7_OUTPUT_CHANNEL_NUM = 10;
   localparam int LAYER8_CHANNEL_NUM        = LAYER7_OUTPUT_CHANNEL_NUM;
   localparam int LAYER8_WORDLENGTH         = 16;
   localparam int LAYER8_IDX_WIDTH          = $clog2(LAYER8_CHANNEL_NUM);

   // Classifier controller states (2-bit encoding).
   typedef enum logic [1:0] {
      LAYER8_IDLE = 2'd0,
      LAYER8_SCAN = 2'd1,
      LAYER8_HOLD = 2'd2
   } layer8_state_e;

endpackage

// File: rtl/layer8_argmax_counter.sv
// Scan-index counter: synchronous clear has priority over increment.
module layer8_argmax_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,     // asynchronous, active-high
   input  logic             clear_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] cnt_q;

   // Count register: clear wins, otherwise step by one when enabled.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/layer8_argmax.sv
// Layer-8 classifier: captures the layer-7 class scores, scans them one
// channel per cycle for the signed maximum, and offers the winning class
// index and score downstream.
//
// Result handshake: result_valid rises with result_class/result_score
// already stable and all three stay frozen until an edge where
// result_valid && result_ready; result_valid drops on the following cycle.
module layer8_argmax
   import layer8_argmax_pkg::*;
#(
   parameter int CHANNEL_NUM = LAYER8_CHANNEL_NUM,
   parameter int WORDLENGTH  = LAYER8_WORDLENGTH,
   parameter int IDX_W       = $clog2(CHANNEL_NUM)
) (
   input  logic                              clk,
   input  logic                              rst,          // async, active-low
   input  logic [WORDLENGTH*CHANNEL_NUM-1:0] fc_data_in,
   input  logic                              fc_done,
   input  logic                              result_ready,
   output logic                              result_valid,
   output logic [IDX_W-1:0]                  result_class,
   output logic [WORDLENGTH-1:0]             result_score,
   output logic                              busy,
   output logic                              overrun,
   output layer8_state_e                     dbg_state
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNEL_NUM - 1);

   layer8_state_e state_q, state_d;

   logic signed [WORDLENGTH-1:0] scores_q [CHANNEL_NUM];
   logic signed [WORDLENGTH-1:0] scores_d [CHANNEL_NUM];

   logic signed [WORDLENGTH-1:0] best_score_q, best_score_d;
   logic [IDX_W-1:0]             best_idx_q, best_idx_d;

   logic                  result_valid_q, result_valid_d;
   logic [IDX_W-1:0]      result_class_q, result_class_d;
   logic [WORDLENGTH-1:0] result_score_q, result_score_d;
   logic                  busy_q, busy_d;
   logic                  overrun_q, overrun_d;

   logic [IDX_W-1:0] cnt;
   logic [IDX_W-1:0] scan_idx;
   logic             cnt_clear;
   logic             cnt_en;
   logic             last_cmp;

   logic signed [WORDLENGTH-1:0] cand_score;
   logic signed [WORDLENGTH-1:0] upd_score;
   logic [IDX_W-1:0]             upd_idx;

   // The counter runs from 0 during SCAN; channel 0 is preloaded as the
   // initial best, so the compared channel is one ahead of the count.
   layer8_argmax_counter #(
      .WIDTH (IDX_W)
   ) u_scan_cnt (
      .clk_i   (clk),
      .rst_i   (~rst),
      .clear_i (cnt_clear),
      .en_i    (cnt_en),
      .count_o (cnt)
   );

   assign scan_idx = cnt + IDX_W'(1);
   assign last_cmp = (scan_idx == LAST_IDX);

   // Select the score under comparison this cycle.
   always_comb begin
      cand_score = '0;
      for (int k = 0; k < CHANNEL_NUM; k++) begin
         if (scan_idx == IDX_W'(k)) begin
            cand_score = scores_q[k];
         end
      end
   end

   // Strict signed compare: on ties the earlier (lower) index is kept.
   always_comb begin
      upd_score = best_score_q;
      upd_idx   = best_idx_q;
      if (cand_score > best_score_q) begin
         upd_score = cand_score;
         upd_idx   = scan_idx;
      end
   end

   // Controller next-state, datapath loads and flag updates.
   always_comb begin
      state_d        = state_q;
      scores_d       = scores_q;
      best_score_d   = best_score_q;
      best_idx_d     = best_idx_q;
      result_valid_d = result_valid_q;
      result_class_d = result_class_q;
      result_score_d = result_score_q;
      overrun_d      = overrun_q;
      cnt_clear      = 1'b1;
      cnt_en         = 1'b0;

      case (state_q)
         LAYER8_IDLE: begin
            if (fc_done) begin
               for (int k = 0; k < CHANNEL_NUM; k++) begin
                  scores_d[k] = fc_data_in[k*WORDLENGTH +: WORDLENGTH];
               end
               best_score_d = fc_data_in[WORDLENGTH-1:0];
               best_idx_d   = '0;
               state_d      = LAYER8_SCAN;
            end
         end

         LAYER8_SCAN: begin
            cnt_clear    = 1'b0;
            cnt_en       = 1'b1;
            best_score_d = upd_score;
            best_idx_d   = upd_idx;
            // A new image cannot be taken mid-scan; remember that one was lost.
            if (fc_done) begin
               overrun_d = 1'b1;
            end
            if (last_cmp) begin
               result_class_d = upd_idx;
               result_score_d = upd_score;
               result_valid_d = 1'b1;
               state_d        = LAYER8_HOLD;
            end
         end

         LAYER8_HOLD: begin
            // Includes the handshake edge: capture only happens from IDLE.
            if (fc_done) begin
               overrun_d = 1'b1;
            end
            if (result_ready) begin
               result_valid_d = 1'b0;
               state_d        = LAYER8_IDLE;
            end
         end

         default: begin
            state_d = LAYER8_IDLE;
         end
      endcase

      busy_d = (state_d != LAYER8_IDLE);
   end

   // State and datapath registers; reset discards any partial scan.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= LAYER8_IDLE;
         for (int k = 0; k < CHANNEL_NUM; k++) begin
            scores_q[k] <= '0;
         end
         best_score_q   <= '0;
         best_idx_q     <= '0;
         result_valid_q <= 1'b0;
         result_class_q <= '0;
         result_score_q <= '0;
         busy_q         <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         scores_q       <= scores_d;
         best_score_q   <= best_score_d;
         best_idx_q     <= best_idx_d;
         result_valid_q <= result_valid_d;
         result_class_q <= result_class_d;
         result_score_q <= result_score_d;
         busy_q         <= busy_d;
         overrun_q      <= overrun_d;
      end
   end

   assign result_valid = result_valid_q;
   assign result_class = result_class_q;
   assign result_score = result_score_q;
   assign busy         = busy_q;
   assign overrun      = overrun_q;
   assign dbg_state    = state_q;

endmodule
